// File: rtl/bcp_dispatch.sv
// Clause-range scheduler feeding a bank of BCP cores: round-robin issue of one
// clause per cycle, outstanding tracking, and a single done/conflict report.
module bcp_dispatch #(
  parameter int NUM_UNITS   = 4,
  parameter int CLAUSE_BITS = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CLAUSE_BITS-1:0] start_clause,
  input  logic [CLAUSE_BITS-1:0] end_clause,
  input  logic                   abort,
  input  logic [NUM_UNITS-1:0]   unit_ready,
  output logic [NUM_UNITS-1:0]   unit_valid,
  output logic [CLAUSE_BITS-1:0] unit_clause_idx,
  input  logic [NUM_UNITS-1:0]   unit_done,
  input  logic [NUM_UNITS-1:0]   unit_conflict,
  output logic                   busy,
  output logic                   done,
  output logic                   conflict,
  output logic [CLAUSE_BITS-1:0] conflict_clause
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_ISSUE  | handing clauses to free cores
  // S_DRAIN  | no more issue, waiting for outstanding cores
  // S_REPORT | one-cycle done pulse with conflict result
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPORT} state_e;

  state_e                 state_q, state_d;
  logic [CLAUSE_BITS-1:0] next_idx_q, next_idx_d;
  logic [CLAUSE_BITS-1:0] end_idx_q, end_idx_d;
  logic [NUM_UNITS-1:0]   outstanding_q, outstanding_d;
  logic [CLAUSE_BITS-1:0] slot_idx_q [NUM_UNITS];
  logic [CLAUSE_BITS-1:0] slot_idx_d [NUM_UNITS];
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   conf_seen_q, conf_seen_d;
  logic [CLAUSE_BITS-1:0] conf_idx_q, conf_idx_d;

  logic [NUM_UNITS-1:0]   eligible;
  logic                   issue_en;
  logic                   issue_hit;
  logic                   issue_fire;
  logic [PTR_W-1:0]       issue_unit;
  logic [PTR_W:0]         cand;

  logic [NUM_UNITS-1:0]   done_hit;
  logic [NUM_UNITS-1:0]   conf_hit;
  logic                   conf_set;
  logic [CLAUSE_BITS-1:0] conf_new_idx;

  // Round-robin pick: first eligible unit at or after rr_ptr, modulo NUM_UNITS.
  always_comb begin
    eligible   = unit_ready & ~outstanding_q;
    issue_en   = (state_q == S_ISSUE) && !conf_seen_q && (next_idx_q != end_idx_q);
    issue_hit  = 1'b0;
    issue_unit = '0;
    cand       = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_UNITS)) begin
        cand = cand - (PTR_W+1)'(NUM_UNITS);
      end
      if (!issue_hit && eligible[cand[PTR_W-1:0]]) begin
        issue_hit  = 1'b1;
        issue_unit = cand[PTR_W-1:0];
      end
    end
    issue_fire = issue_en && issue_hit;
  end

  always_comb begin
    unit_valid      = '0;
    unit_clause_idx = '0;
    if (issue_fire) begin
      unit_valid[issue_unit] = 1'b1;
      unit_clause_idx        = next_idx_q;
    end
  end

  // Completions only count against registered outstanding bits; lowest unit wins a tie.
  always_comb begin
    done_hit     = (state_q != S_IDLE) ? (unit_done & outstanding_q) : '0;
    conf_hit     = done_hit & unit_conflict;
    conf_set     = 1'b0;
    conf_new_idx = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (!conf_set && !conf_seen_q && conf_hit[k]) begin
        conf_set     = 1'b1;
        conf_new_idx = slot_idx_q[k];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    next_idx_d    = next_idx_q;
    end_idx_d     = end_idx_q;
    outstanding_d = outstanding_q;
    slot_idx_d    = slot_idx_q;
    rr_ptr_d      = rr_ptr_q;
    conf_seen_d   = conf_seen_q;
    conf_idx_d    = conf_idx_q;

    if (abort) begin
      state_d       = S_IDLE;
      outstanding_d = '0;
    end else begin
      outstanding_d = outstanding_q & ~done_hit;
      if (conf_set) begin
        conf_seen_d = 1'b1;
        conf_idx_d  = conf_new_idx;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            next_idx_d  = start_clause;
            end_idx_d   = end_clause;
            conf_seen_d = 1'b0;
            conf_idx_d  = '0;
            state_d     = (start_clause >= end_clause) ? S_REPORT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            outstanding_d[issue_unit] = 1'b1;
            slot_idx_d[issue_unit]    = next_idx_q;
            next_idx_d                = next_idx_q + CLAUSE_BITS'(1);
            rr_ptr_d = (issue_unit == PTR_W'(NUM_UNITS - 1)) ? '0 : issue_unit + PTR_W'(1);
          end
          if (conf_set || (issue_fire && (next_idx_d == end_idx_q))) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (outstanding_q == '0) begin
            state_d = S_REPORT;
          end
        end
        S_REPORT: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      next_idx_q    <= '0;
      end_idx_q     <= '0;
      outstanding_q <= '0;
      slot_idx_q    <= '{default: '0};
      rr_ptr_q      <= '0;
      conf_seen_q   <= 1'b0;
      conf_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      end_idx_q     <= end_idx_d;
      outstanding_q <= outstanding_d;
      slot_idx_q    <= slot_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      conf_seen_q   <= conf_seen_d;
      conf_idx_q    <= conf_idx_d;
    end
  end

  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_REPORT);
    conflict        = done && conf_seen_q;
    conflict_clause = conflict ? conf_idx_q : '0;
  end

endmodule

// File: tb/tb_bcp_dispatch.sv
// Bench for bcp_dispatch: directed scenario table, abort sequence, and random
// sweeps against a transaction-level reference with emulated BCP cores.
module tb_bcp_dispatch;
  localparam int N  = 4;
  localparam int CB = 10;

  logic          clock = 1'b0;
  logic          reset, start, abort;
  logic [CB-1:0] start_clause, end_clause;
  logic [N-1:0]  unit_ready, unit_valid, unit_done, unit_conflict;
  logic [CB-1:0] unit_clause_idx, conflict_clause;
  logic          busy, done, conflict;

  always #5 clock = ~clock;

  bcp_dispatch #(.NUM_UNITS(N), .CLAUSE_BITS(CB)) dut (
    .clock(clock), .reset(reset), .start(start), .start_clause(start_clause),
    .end_clause(end_clause), .abort(abort), .unit_ready(unit_ready),
    .unit_valid(unit_valid), .unit_clause_idx(unit_clause_idx),
    .unit_done(unit_done), .unit_conflict(unit_conflict), .busy(busy),
    .done(done), .conflict(conflict), .conflict_clause(conflict_clause)
  );

  int n_vec = 0, n_err = 0;
  int gcyc = 0, cyc0 = 0;

  // reference sweep state
  bit m_busy, m_issuing, m_conf;
  int m_next, m_end, m_rr, m_cidx, m_done_cyc, m_phase_end, m_last_comp;
  int pend [N];
  // emulated cores
  bit core_busy [N];
  int core_due [N];
  bit core_cf [N];
  bit rand_mode;
  logic [N-1:0][3:0] cur_lat;
  int conf_a, conf_b;
  // observed results of the current sweep
  int obs_done_cyc, obs_conf, obs_cidx, obs_issues;

  typedef struct {
    int s; int e; logic [N-1:0] rdy; logic [N-1:0][3:0] lat; int ca; int cb;
    int x_done; int x_conf; int x_cidx; int x_issues;
  } vec_t;
  vec_t tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issuing = 0; m_conf = 0; m_next = 0; m_end = 0; m_rr = 0;
    m_cidx = 0; m_done_cyc = -1; m_phase_end = -1; m_last_comp = -1;
    for (int k = 0; k < N; k++) begin
      pend[k] = -1; core_busy[k] = 0; core_due[k] = 0; core_cf[k] = 0;
    end
  endtask

  task automatic obs_clear();
    obs_done_cyc = -1; obs_conf = -1; obs_cidx = -1; obs_issues = 0;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; unit_ready = '1; unit_done = '0; unit_conflict = '0;
    start_clause = '0; end_clause = '0; reset = 1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", unit_valid, 0);
    chk("reset_clause_idx", unit_clause_idx, 0);
    chk("reset_conflict", conflict, 0);
    chk("reset_conflict_clause", conflict_clause, 0);
    reset = 0;
    model_reset();
  endtask

  task automatic step(input bit st, input int s, input int e, input bit ab,
                      input logic [N-1:0] rdy, input logic [N-1:0] xdone,
                      input logic [N-1:0] xconf);
    logic [N-1:0] dn, cf, exp_valid, idle_mask;
    int exp_k, exp_idx, k, t, cl;
    bit exp_done, all_empty;
    @(negedge clock);
    for (int i = 0; i < N; i++) idle_mask[i] = !core_busy[i];
    dn = xdone & idle_mask;
    cf = xconf & dn;
    for (int i = 0; i < N; i++) begin
      if (core_busy[i] && core_due[i] == gcyc) begin
        dn[i] = 1'b1;
        cf[i] = core_cf[i];
      end
    end
    start = st; start_clause = CB'(s); end_clause = CB'(e); abort = ab;
    unit_ready = rdy; unit_done = dn; unit_conflict = cf;
    #1;
    exp_k = -1;
    if (m_busy && m_issuing) begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (exp_k < 0 && rdy[k] && pend[k] < 0) exp_k = k;
      end
    end
    exp_valid = '0;
    if (exp_k >= 0) exp_valid[exp_k] = 1'b1;
    exp_idx  = (exp_k >= 0) ? m_next : 0;
    exp_done = m_busy && (m_done_cyc == gcyc);
    chk("unit_valid", unit_valid, exp_valid);
    chk("unit_clause_idx", unit_clause_idx, exp_idx);
    chk("busy", busy, m_busy);
    chk("done", done, exp_done);
    chk("conflict", conflict, exp_done && m_conf);
    chk("conflict_clause", conflict_clause, (exp_done && m_conf) ? m_cidx : 0);
    if (unit_valid != '0) obs_issues++;
    if (done) begin
      obs_done_cyc = gcyc - cyc0; obs_conf = conflict; obs_cidx = conflict_clause;
    end

    // effect of the coming clock edge on the reference
    if (ab) begin
      m_busy = 0; m_issuing = 0; m_done_cyc = -1;
      for (int i = 0; i < N; i++) begin pend[i] = -1; core_busy[i] = 0; end
    end else begin
      if (m_busy && m_done_cyc == gcyc) begin
        m_busy = 0; m_done_cyc = -1;
      end else if (!m_busy) begin
        if (st) begin
          m_next = s; m_end = e; m_conf = 0; m_busy = 1;
          m_phase_end = -1; m_last_comp = -1;
          if (s >= e) begin m_issuing = 0; m_done_cyc = gcyc + 1; end
          else m_issuing = 1;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (dn[i] && pend[i] >= 0) begin
            if (cf[i] && !m_conf) begin m_conf = 1; m_cidx = pend[i]; m_issuing = 0; end
            pend[i] = -1;
            m_last_comp = gcyc;
          end
        end
        if (exp_k >= 0) begin
          pend[exp_k] = m_next; m_next++; m_rr = (exp_k + 1) % N;
          if (m_next == m_end) begin m_issuing = 0; m_phase_end = gcyc; end
        end
        all_empty = 1;
        for (int i = 0; i < N; i++) if (pend[i] >= 0) all_empty = 0;
        if (!m_issuing && all_empty && m_done_cyc < 0) begin
          t = (m_phase_end > m_last_comp) ? m_phase_end : m_last_comp;
          m_done_cyc = t + 2;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (core_busy[i] && core_due[i] == gcyc) core_busy[i] = 0;
        if (unit_valid[i] && rdy[i]) begin
          cl = int'(unit_clause_idx);
          core_busy[i] = 1;
          core_due[i]  = gcyc + (rand_mode ? int'($urandom_range(1, 4)) : int'(cur_lat[i]));
          core_cf[i]   = rand_mode ? ($urandom_range(0, 9) == 0) : (cl == conf_a || cl == conf_b);
        end
      end
    end
    gcyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc1, s, e;
    logic [N-1:0] r;
    tab[0] = '{5,    9,    4'b1111, 16'h3333, -1,  -1, 9,  0, 0,   4};
    tab[1] = '{0,    10,   4'b0100, 16'h1111, -1,  -1, 22, 0, 0,   10};
    tab[2] = '{20,   30,   4'b1111, 16'h2222, 21,  -1, 8,  1, 21,  4};
    tab[3] = '{40,   44,   4'b1111, 16'h1114, 40,  43, 7,  1, 40,  4};
    tab[4] = '{7,    7,    4'b1111, 16'h1111, -1,  -1, 1,  0, 0,   0};
    tab[5] = '{9,    3,    4'b1111, 16'h1111, -1,  -1, 1,  0, 0,   0};
    tab[6] = '{1021, 1023, 4'b1111, 16'h1111, -1,  -1, 5,  0, 0,   2};
    tab[7] = '{100,  106,  4'b0011, 16'h2222, 100, -1, 6,  1, 100, 2};

    rand_mode = 0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cur_lat = tab[i].lat; conf_a = tab[i].ca; conf_b = tab[i].cb;
      cyc0 = gcyc; obs_clear();
      step(1, tab[i].s, tab[i].e, 0, tab[i].rdy, '0, '0);
      for (int c = 0; c < 60; c++) begin
        if (obs_done_cyc >= 0 && (gcyc - cyc0) > obs_done_cyc + 2) break;
        step(0, 0, 0, 0, tab[i].rdy, '0, '0);
      end
      chk($sformatf("vec%0d_done_cycle", i), obs_done_cyc, tab[i].x_done);
      chk($sformatf("vec%0d_conflict", i), obs_conf, tab[i].x_conf);
      chk($sformatf("vec%0d_conflict_clause", i), obs_cidx, tab[i].x_cidx);
      chk($sformatf("vec%0d_issue_count", i), obs_issues, tab[i].x_issues);
    end

    // abort mid-sweep with two clauses outstanding, then a fresh sweep with stray completions
    do_reset();
    cur_lat = 16'h6666; conf_a = -1; conf_b = -1;
    cyc0 = gcyc; obs_clear();
    step(1, 50, 60, 0, 4'b1111, '0, '0);
    step(0, 0, 0, 0, 4'b1111, '0, '0);
    step(0, 0, 0, 0, 4'b1111, '0, '0);
    chk("abort_issued_before", obs_issues, 2);
    step(0, 0, 0, 1, 4'b0000, '0, '0);
    step(0, 0, 0, 0, 4'b1111, 4'b0011, 4'b0011);
    chk("abort_busy_after", busy, 0);
    chk("abort_no_done", obs_done_cyc, -1);
    cyc1 = gcyc; cyc0 = cyc1; obs_clear();
    step(1, 60, 62, 0, 4'b1111, '0, '0);
    for (int c = 0; c < 40; c++) begin
      if (obs_done_cyc >= 0 && (gcyc - cyc0) > obs_done_cyc + 2) break;
      step(0, 0, 0, 0, 4'b1111, 4'b0011, 4'b0011);
    end
    chk("restart_done_cycle", obs_done_cyc, 10);
    chk("restart_conflict", obs_conf, 0);
    chk("restart_issue_count", obs_issues, 2);

    // random sweeps
    rand_mode = 1;
    do_reset();
    cyc0 = gcyc; obs_clear();
    for (int c = 0; c < 4000; c++) begin
      s = int'($urandom_range(0, 60));
      e = s + int'($urandom_range(0, 14)) - 2;
      if (e < 0) e = 0;
      if ($urandom_range(0, 15) == 0) begin
        s = 1023 - int'($urandom_range(0, 6));
        e = s + int'($urandom_range(0, 3));
        if (e > 1023) e = 1023;
      end
      r = N'($urandom) | N'($urandom);
      step($urandom_range(0, 3) == 0, s, e, $urandom_range(0, 299) == 0, r,
           ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcp_dispatch.md
# bcp_dispatch

Clause-range scheduler between the solver control FSM and a bank of NUM_UNITS parallel BCP cores. On `start` it latches a variable's clause range `[start_clause, end_clause)` from the var start/end table, issues one clause index per cycle to free cores in round-robin order, and tracks outstanding work. It reports one `done` pulse with a sticky conflict flag and the first conflicting clause index. A conflict stops further issue. `abort` cancels the sweep for backtracking.

## Interface
Parameters:
- NUM_UNITS, 4, number of BCP cores served (2..8)
- CLAUSE_BITS, 10, clause index width (matches `MAX_CLAUSES_BITS`)

Ports:
- clock  in  1  system clock; all state on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin sweep; sampled only in IDLE
- start_clause  in  CLAUSE_BITS  first clause index (inclusive)
- end_clause  in  CLAUSE_BITS  last clause index (exclusive)
- abort  in  1  cancel sweep; highest priority after reset
- unit_ready  in  NUM_UNITS  core k can accept a clause this cycle
- unit_valid  out  NUM_UNITS  one-hot issue strobe; bit k high only if unit_ready[k]
- unit_clause_idx  out  CLAUSE_BITS  clause index for the issued core
- unit_done  in  NUM_UNITS  core k finished its clause (1-cycle pulse)
- unit_conflict  in  NUM_UNITS  qualifies unit_done[k]: clause evaluated false
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle completion pulse
- conflict  out  1  valid with done: a conflict was seen
- conflict_clause  out  CLAUSE_BITS  valid with done&conflict: first conflicting clause

## Operation
- States: IDLE, ISSUE, DRAIN, REPORT.
- Internal registers:
  - `next_idx` (CLAUSE_BITS)
  - `end_idx`
  - `outstanding[NUM_UNITS]`
  - `slot_idx[k]`, the clause held by core k
  - `rr_ptr`
  - sticky `conf_seen`
  - `conf_idx`
- IDLE with start=1:
  - Latch end_idx=end_clause and next_idx=start_clause.
  - Clear conf_seen.
  - If start_clause >= end_clause (empty range), go to REPORT with conflict=0. Otherwise go to ISSUE.
- ISSUE:
  - The eligible set is units with unit_ready[k]=1 and outstanding[k]=0.
  - Scan from rr_ptr upward, mod NUM_UNITS. The first eligible unit k gets unit_valid[k]=1 and unit_clause_idx=next_idx.
  - On issue: set outstanding[k], set slot_idx[k]=next_idx, increment next_idx, set rr_ptr=(k+1) mod NUM_UNITS.
  - After issuing the clause end_idx-1, go to DRAIN.
  - If no unit is eligible, hold with no issue.
- Completion, in any non-IDLE state:
  - unit_done[k] with outstanding[k]=1 clears outstanding[k].
  - unit_done[k] with outstanding[k]=0 is ignored.
  - If unit_conflict[k] is also high and conf_seen=0, set conf_seen and conf_idx=slot_idx[k].
  - If several units complete with conflict in the same cycle, the lowest k wins.
- Conflict while in ISSUE: no issue occurs in the cycle after conf_seen sets. Go to DRAIN.
- DRAIN: no issue. When outstanding is all-zero, go to REPORT.
- REPORT:
  - done=1 for this cycle only; conflict=conf_seen.
  - conflict_clause=conf_idx when conf_seen=1, otherwise 0.
  - Next state is IDLE.
- abort=1 in any state:
  - Next state is IDLE, outstanding is cleared, and there is no done pulse.
  - Cores are reset separately by control (`reset_bcp`).
- start while busy is ignored.

## Timing
- Reset (synchronous) values:
  - State IDLE; busy, done, conflict 0; conflict_clause 0.
  - unit_valid 0; unit_clause_idx 0.
  - next_idx, outstanding, rr_ptr, conf_seen, conf_idx 0.
- unit_valid and unit_clause_idx are combinational from registered state and unit_ready. unit_clause_idx=0 when no issue.
- Handshake: a core accepts on the posedge where unit_valid[k]&unit_ready[k].
- Latency from start (cycle 0):
  - First issue in cycle 1 at the earliest.
  - At most one issue per cycle.
  - done no earlier than 1 cycle after the last completion clears outstanding.
  - Empty range: done in cycle 1.
- Same-cycle issue and done on a unit: completion clears first (from the registered outstanding bit). The core is eligible again the next cycle.
- No wrap-around: issue stops at next_idx==end_idx. end_clause=2^CLAUSE_BITS-1 needs no extra bit.
- Same-cycle abort and unit_done: abort wins and the completion is discarded.
- busy deasserts in the cycle after REPORT or after abort.

## Test plan
- Range [5,9), NUM_UNITS=4, all ready, each done 3 cycles after issue, no conflict:
  - Issues 5,6,7,8 to units 0,1,2,3 in cycles 1-4.
  - One done pulse with conflict=0; busy 0 afterwards.
- Range [0,10), only unit 2 ready:
  - All 10 clauses go to unit 2, in order, each only after the prior done.
  - rr_ptr skips the unready units; done after the 10th completion.
- Range [20,30); unit 1 reports conflict on clause 21 while 22 and 23 are outstanding:
  - No issue after the conflict cycle; drain waits for 22 and 23.
  - done with conflict=1, conflict_clause=21.
- Units 0 and 3 signal conflict in the same cycle on clauses 40 and 43: conflict_clause=40.
- start with start_clause=7, end_clause=7: no unit_valid; done=1, conflict=0 in cycle 1.
- abort in mid-ISSUE with 2 outstanding:
  - Next cycle IDLE, busy=0, no done.
  - A new start is then accepted, and stray unit_done pulses from the old sweep are ignored.
